// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - state_e   : controller states (clear sequence, normal operation)
//   - Def*      : default parameter values for regfile_mp
//   - ByteW     : granularity of byte-enable merging
package regfile_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNumRd = 2;

  localparam int unsigned ByteW = 8;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_mp.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   run             : high once the clear sequence has finished
//   rd_en, rd_addr  : read request and address for this port
//   mem             : storage array contents
//   wr_fire         : a qualified write happens on this edge
//   wr_addr/_data/_be : the qualified write, for write-first bypass
//   rd_data         : registered read data (latency 1)
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 2 ** DefAddrW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        mem [DEPTH],
  input  logic                     wr_fire,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/ByteW-1:0]  wr_be,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned BeW = DATA_W / ByteW;

  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  // Write-first: a same-edge write to this address is merged byte by byte
  // over the stored value. Entry 0 is never cleared, so it is forced to zero.
  always_comb begin
    merged = mem[rd_addr];
    if (wr_fire && (wr_addr == rd_addr)) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (wr_be[b]) merged[b*ByteW +: ByteW] = wr_data[b*ByteW +: ByteW];
      end
    end
    if (rd_addr == '0) merged = '0;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (!run) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      rd_data_d = merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enable writes.
// After reset a clear sequence zeroes entries 1..DEPTH-1 (one per edge);
// entry 0 always reads as zero. ready rises once clearing is done.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   wr_en/addr/data/be    : single write port with byte enables
//   rd_en, rd_addr        : per-port read enables, packed addresses
//   rd_data               : packed registered read data, latency 1
//   ready                 : clear sequence finished, accesses accepted
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/ByteW-1:0]  wr_be,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BeW   = DATA_W / ByteW;

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] clr_idx_d, clr_idx_q;
  logic              ready_d, ready_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              run;
  logic              wr_fire;

  assign run     = (state_q == StRun);
  assign wr_fire = run && wr_en && (wr_addr != '0) && (wr_be != '0);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    unique case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = StRun;
          ready_d   = 1'b1;
          clr_idx_d = ADDR_W'(1);
        end
      end
      StRun: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= ADDR_W'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Storage is intentionally not reset; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_fire) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (wr_be[b]) mem_q[wr_addr][b*ByteW +: ByteW] <= wr_data[b*ByteW +: ByteW];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_rd_port (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .rd_en   (rd_en[p]),
      .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
      .mem     (mem_q),
      .wr_fire (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .rd_data (rd_data[p*DATA_W +: DATA_W])
    );
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        ready;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge, sample 1ns after the next rising edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic [1:0] re,
                     input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = {ra1, ra0};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", ready);
    end
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 0", rd_data);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_clear;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== (e == 31)) begin
        errors++;
        $display("FAIL clear_ready edge %0d: got %b expected %b", e, ready, (e == 31));
      end
    end
    for (int a = 0; a < 32; a += 2) begin
      cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'(a), 5'(a + 1));
      checks++;
      if (rd_data !== 64'h0) begin
        errors++;
        $display("FAIL clear_entries x%0d/x%0d: got %h expected 0", a, a + 1, rd_data);
      end
    end
  endtask

  task automatic test_masked_write;
    cyc(1'b1, 5'd5, 32'hAABBCCDD, 4'b1111, 2'b00, 5'd0, 5'd0);
    cyc(1'b1, 5'd5, 32'h11223344, 4'b0101, 2'b00, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd5, 5'd5);
    checks++;
    if (rd_data !== {32'hAA22CC44, 32'hAA22CC44}) begin
      errors++;
      $display("FAIL masked_write: got %h expected aa22cc44 on both", rd_data);
    end
    // All-zero byte enables must not change the entry.
    cyc(1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000, 2'b00, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b01, 5'd5, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL zero_be_noop: got %h expected aa22cc44", rd_data[31:0]);
    end
  endtask

  task automatic test_bypass;
    cyc(1'b1, 5'd7, 32'hDEADBEEF, 4'b1111, 2'b01, 5'd7, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_full: got %h expected deadbeef", rd_data[31:0]);
    end
    // Partial same-edge write merges old upper bytes with new lower bytes.
    cyc(1'b1, 5'd7, 32'h00000000, 4'b0011, 2'b10, 5'd0, 5'd7);
    checks++;
    if (rd_data[63:32] !== 32'hDEAD0000) begin
      errors++;
      $display("FAIL bypass_partial: got %h expected dead0000", rd_data[63:32]);
    end
  endtask

  task automatic test_x0;
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111, 2'b00, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd0, 5'd0);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL x0_read: got %h expected 0", rd_data);
    end
    // Load nonzero first so a same-edge x0 write+read must return zero.
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b01, 5'd5, 5'd0);
    cyc(1'b1, 5'd0, 32'h12345678, 4'b1111, 2'b01, 5'd0, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass: got %h expected 0", rd_data[31:0]);
    end
  endtask

  task automatic test_hold_dual;
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd5, 5'd7);
    checks++;
    if (rd_data !== {32'hDEAD0000, 32'hAA22CC44}) begin
      errors++;
      $display("FAIL dual_port: got %h expected dead0000aa22cc44", rd_data);
    end
    cyc(1'b1, 5'd5, 32'h12345678, 4'b1111, 2'b00, 5'd5, 5'd7);
    checks++;
    if (rd_data !== {32'hDEAD0000, 32'hAA22CC44}) begin
      errors++;
      $display("FAIL hold: got %h expected dead0000aa22cc44", rd_data);
    end
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b10, 5'd0, 5'd5);
    checks++;
    if (rd_data !== {32'h12345678, 32'hAA22CC44}) begin
      errors++;
      $display("FAIL hold_write_landed: got %h expected 12345678aa22cc44", rd_data);
    end
  endtask

  task automatic test_reset_run;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hCAFEF00D;
    wr_be   = 4'b1111;
    rd_en   = 2'b11;
    rd_addr = {5'd5, 5'd5};
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL run_reset_ready: got %b expected 0", ready);
    end
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL run_reset_rd_data: got %h expected 0", rd_data);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Accesses stay asserted through the clear sequence and must be ignored.
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== (e == 31)) begin
        errors++;
        $display("FAIL reclear_ready edge %0d: got %b expected %b", e, ready, (e == 31));
      end
      checks++;
      if (rd_data !== 64'h0) begin
        errors++;
        $display("FAIL reclear_rd_data edge %0d: got %h expected 0", e, rd_data);
      end
    end
    cyc(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd5, 5'd7);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reclear_x5_x7: got %h expected 0", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_masked_write();
    test_bypass();
    test_x0();
    test_hold_dual();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports (legal range 1..4).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en  input  1  meaning write request this cycle.
REQ-007 SHALL have port wr_addr  input  ADDR_W  meaning write address.
REQ-008 SHALL have port wr_data  input  DATA_W  meaning write data.
REQ-009 SHALL have port wr_be  input  DATA_W/8  meaning byte enables; bit i covers byte i.
REQ-010 SHALL have port rd_en  input  NUM_RD  meaning per-port read enable.
REQ-011 SHALL have port rd_addr  input  NUM_RD*ADDR_W  meaning packed read addresses; port p in slice p.
REQ-012 SHALL have port rd_data  output  NUM_RD*DATA_W  meaning packed registered read data.
REQ-013 SHALL have port ready  output  1  meaning clear sequence done; accesses accepted.

Function
REQ-014 SHALL hold a two-state FSM: CLEAR and RUN.
REQ-015 SHALL, in CLEAR, write zero to entry clr_idx on each edge, starting at clr_idx=1 and incrementing; on the edge clearing DEPTH-1 it SHALL enter RUN and set ready=1 (ready high after exactly DEPTH-1 edges).
REQ-016 SHALL, in CLEAR, ignore wr_en and rd_en, drive rd_data to zero and keep ready=0.
REQ-017 SHALL, in RUN, on an edge with wr_en=1 and wr_addr!=0, update only the bytes with wr_be[i]=1; other bytes keep their values.
REQ-018 SHALL treat a write to address 0, or with wr_be all zero, as a no-op.
REQ-019 SHALL give read latency 1: on an edge with rd_en[p]=1, rd_data slice p loads the entry at rd_addr slice p.
REQ-020 SHALL hold rd_data slice p unchanged on edges with rd_en[p]=0.
REQ-021 SHALL return zero for any read of address 0, regardless of writes.
REQ-022 SHALL be write-first: a read and a write to the same nonzero address on the same edge return the merged post-write value (old bytes where wr_be=0, new bytes where wr_be=1).
REQ-023 SHALL let all read ports access any address, including the same address, independently on the same edge.

Reset
REQ-024 SHALL, on reset assertion and without waiting for clk, force state=CLEAR, clr_idx=1, ready=0 and all rd_data=0.
REQ-025 SHALL treat reset during CLEAR or RUN identically: the clear sequence restarts from entry 1 after deassertion.
REQ-026 SHALL NOT reset the storage array directly; the clear sequence alone zeroes it.

Structure
REQ-027 SHALL place the FSM state enum, the default parameter values and the byte-merge width constant in shared package regfile_pkg.
REQ-028 SHALL implement one read port (address decode, x0 zeroing, write-first bypass, output register) as sub-module regfile_rd_port, instantiated NUM_RD times.

Verification (DATA_W=32, ADDR_W=5, NUM_RD=2)
REQ-029 SHALL check clear: release reset -> ready=0 for 30 edges, ready=1 after edge 31; all entries then read 0x00000000.
REQ-030 SHALL check masked write: write 0xAABBCCDD to x5 with be=1111, then 0x11223344 with be=0101 -> x5 reads 0xAA22CC44 one cycle after rd_en.
REQ-031 SHALL check bypass: same-edge write 0xDEADBEEF to x7 (be=1111) and read x7 on port 0 -> rd_data0=0xDEADBEEF on the next cycle.
REQ-032 SHALL check x0: write 0xFFFFFFFF to x0, then read x0 on both ports -> both rd_data slices = 0x00000000.
REQ-033 SHALL check hold and dual port: read x5 on port 0 and x7 on port 1, then drop rd_en while writing x5 -> rd_data unchanged.
REQ-034 SHALL check reset in RUN: assert reset mid-write -> ready=0 and rd_data=0 at once; after release, ready returns after 31 edges and x5 reads 0.
